rob_phase_tracker: RTL and testbench
====================================

ROB_PHASE_TRACKER -- requirements
Module: rob_phase_tracker

Interface
REQ-001 Parameter NCH, default 2: retire/commit channels sampled per cycle (1..8).
REQ-002 Parameter FIFO_DEPTH, default 8: event FIFO entries, power of two, >=2.
REQ-003 Parameter CNT_W, default 32: timestamp and duration width.
REQ-004 Parameter TAINT_W, default 32: taint sum width.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 commit_valid  input  NCH  per-slot retire valid.
REQ-008 commit_inst  input  NCH*32  per-slot retired instruction; slot i at bits [32i+31:32i].
REQ-009 taint_sum  input  TAINT_W  current design taint sum.
REQ-010 evt_valid  output  1  FIFO head valid.
REQ-011 evt_ready  input  1  consumer accepts head when evt_valid & evt_ready.
REQ-012 evt_code  output  4  marker code (phase = code>>1; even START, odd END).
REQ-013 evt_slot  output  max(1,$clog2(NCH))  originating slot.
REQ-014 evt_time  output  CNT_W  cycle timestamp of marker retirement.
REQ-015 evt_cycles  output  CNT_W  phase duration on END; 0 on START.
REQ-016 evt_unmatched  output  1  END with phase not active.
REQ-017 evt_taint_peak  output  TAINT_W  peak taint_sum over phase (macro only, REQ-036).
REQ-018 active_phases  output  7  per-phase active bits (0 VCTM,1 DELAY,2 TEXE,3 LEAK,4 INIT,5 BIM,6 TRAIN).
REQ-019 overflow  output  1  sticky: an event was dropped.
REQ-020 drop_cnt  output  16  dropped events, saturating at 16'hFFFF.

Function
REQ-021 Marker: commit_valid[i] & inst[19:0]==20'h02013 & inst[31:24]==0 & code=inst[23:20] <= 13; codes 14/15 ignored.
REQ-022 Free-running counter now: 0 after reset, +1 per cycle, wraps modulo 2^CNT_W; evt_time = now in marker cycle.
REQ-023 Same-cycle markers processed in ascending slot order; each sees phase state updated by lower slots.
REQ-024 START: active set, start time=now, peak=taint_sum; START on active phase restarts (no error).
REQ-025 END on active phase: evt_cycles = (now - start) mod 2^CNT_W, active cleared, evt_unmatched=0.
REQ-026 END on inactive phase: evt_cycles=0, evt_unmatched=1, state unchanged.
REQ-027 START then END of same phase in one cycle: evt_cycles=0, phase ends inactive.
REQ-028 Phase state updates in marker cycle regardless of FIFO space; event appears at FIFO head no earlier than next cycle.
REQ-029 FIFO writes up to NCH entries per cycle; free = FIFO_DEPTH - count + (pop ? 1 : 0).
REQ-030 Events beyond free dropped, higher slots first; overflow set, drop_cnt += dropped (saturating).
REQ-031 evt_* fields stable while evt_valid & !evt_ready; FIFO order = time then slot order.
REQ-032 Empty FIFO: evt_valid=0, other evt_* outputs 0.

Reset
REQ-033 reset low at rising edge: now=0, FIFO empty, evt_valid=0, all evt_* 0, active_phases=0, overflow=0, drop_cnt=0, start/peak registers 0.
REQ-034 Reset mid-phase or with FIFO non-empty discards all state; markers in reset cycle ignored.

Configuration
REQ-035 Macro PHASE_TAINT_PEAK_EN selects per-phase taint peak tracking.
REQ-036 Defined: each active phase peak = max(peak, taint_sum) per cycle (unsigned); END emits peak in evt_taint_peak; START/unmatched emit 0.
REQ-037 Undefined: no peak registers, evt_taint_peak tied to 0, taint_sum unused.

Verification
REQ-038 Reset release, slot0 0x00002013 at now=10, slot0 0x00102013 at now=25 -> START event time 10, END event time 25 cycles 15; active_phases[0] 1 then 0.
REQ-039 NCH=2, one cycle slot0 0x00402013, slot1 0x00502013 -> two events slot 0 then 1, END cycles 0, unmatched 0, active_phases[2]=0.
REQ-040 0x00702013 with LEAK inactive -> evt_unmatched=1, cycles 0; code 0x00e02013 -> no event.
REQ-041 evt_ready=0, FIFO_DEPTH=8, 10 markers -> 8 retained in order, overflow=1, drop_cnt=2; full with pop and 1 push -> no drop.
REQ-042 now started at 2^CNT_W-3, START then END 5 cycles later -> evt_cycles=5.
REQ-043 PHASE_TAINT_PEAK_EN: taint_sum 3,9,4 during TEXE -> END evt_taint_peak=9; without macro -> 0.

Source files
------------

// File: rtl/rob_phase_tracker.sv
// Tracks start/end phase markers retired on the commit channels and queues timed events.
// Optional macro PHASE_TAINT_PEAK_EN adds per-phase peak taint tracking.
module rob_phase_tracker #(
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32,
    parameter int TAINT_W    = 32,
    localparam int SLOT_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH-1:0]       commit_valid,
    input  logic [NCH*32-1:0]    commit_inst,
    input  logic [TAINT_W-1:0]   taint_sum,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [3:0]           evt_code,
    output logic [SLOT_W-1:0]    evt_slot,
    output logic [CNT_W-1:0]     evt_time,
    output logic [CNT_W-1:0]     evt_cycles,
    output logic                 evt_unmatched,
    output logic [TAINT_W-1:0]   evt_taint_peak,
    output logic [6:0]           active_phases,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);
    localparam int NPH   = 7;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 5;

    function automatic logic is_marker(input logic [31:0] inst);
        return (inst[19:0] == 20'h02013) && (inst[31:24] == 8'h00) && (inst[23:20] <= 4'd13);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [CNT_W-1:0]  now;
    logic [NPH-1:0]    active, act_n;
    logic [CNT_W-1:0]  start_time [NPH];
    logic [CNT_W-1:0]  start_n    [NPH];
    logic [2:0]        ph;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              pop;

    logic [3:0]        fifo_code   [FIFO_DEPTH];
    logic [SLOT_W-1:0] fifo_slot   [FIFO_DEPTH];
    logic [CNT_W-1:0]  fifo_time   [FIFO_DEPTH];
    logic [CNT_W-1:0]  fifo_cycles [FIFO_DEPTH];
    logic              fifo_unm    [FIFO_DEPTH];

    logic [NCH-1:0]    ev_ok, ev_unm, wr_en;
    logic [3:0]        ev_code   [NCH];
    logic [CNT_W-1:0]  ev_cycles [NCH];
    logic [PTR_W-1:0]  wr_idx    [NCH];
    logic [CW-1:0]     free_cnt, npush, ndrop;

`ifdef PHASE_TAINT_PEAK_EN
    logic [TAINT_W-1:0] peak      [NPH];
    logic [TAINT_W-1:0] peak_n    [NPH];
    logic [TAINT_W-1:0] ev_peak   [NCH];
    logic [TAINT_W-1:0] fifo_peak [FIFO_DEPTH];
`else
    logic unused_taint;
    assign unused_taint = ^taint_sum;
`endif

    assign evt_valid = (count != '0);
    assign pop       = evt_valid & evt_ready;

    // Marker decode: slots walk in ascending order, each seeing lower-slot updates.
    always_comb begin
        act_n   = active;
        start_n = start_time;
        ev_ok   = '0;
        ev_unm  = '0;
        ph      = '0;
        for (int i = 0; i < NCH; i++) begin
            ev_code[i]   = '0;
            ev_cycles[i] = '0;
        end
`ifdef PHASE_TAINT_PEAK_EN
        peak_n = peak;
        for (int p = 0; p < NPH; p++)
            if (active[p] && taint_sum > peak_n[p]) peak_n[p] = taint_sum;
        for (int i = 0; i < NCH; i++) ev_peak[i] = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (commit_valid[i] && is_marker(commit_inst[32*i +: 32])) begin
                ev_ok[i]   = 1'b1;
                ev_code[i] = commit_inst[32*i+20 +: 4];
                ph         = ev_code[i][3:1];
                if (!ev_code[i][0]) begin
                    act_n[ph]   = 1'b1;
                    start_n[ph] = now;
`ifdef PHASE_TAINT_PEAK_EN
                    peak_n[ph]  = taint_sum;
`endif
                end else if (act_n[ph]) begin
                    ev_cycles[i] = now - start_n[ph];
                    act_n[ph]    = 1'b0;
`ifdef PHASE_TAINT_PEAK_EN
                    ev_peak[i]   = peak_n[ph];
`endif
                end else begin
                    ev_unm[i] = 1'b1;
                end
            end
        end
    end

    // FIFO slot allocation: lower slots claim free entries first, the rest drop.
    always_comb begin
        free_cnt = CW'(FIFO_DEPTH) - CW'(count) + CW'(pop);
        npush    = '0;
        ndrop    = '0;
        wr_en    = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_idx[i] = '0;
            if (ev_ok[i]) begin
                if (npush < free_cnt) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = wr_ptr + npush[PTR_W-1:0];
                    npush     = npush + 1'b1;
                end else begin
                    ndrop = ndrop + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            now      <= '0;
            active   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            for (int p = 0; p < NPH; p++) begin
                start_time[p] <= '0;
`ifdef PHASE_TAINT_PEAK_EN
                peak[p]       <= '0;
`endif
            end
        end else begin
            now        <= now + 1'b1;
            active     <= act_n;
            start_time <= start_n;
`ifdef PHASE_TAINT_PEAK_EN
            peak       <= peak_n;
`endif
            wr_ptr     <= wr_ptr + npush[PTR_W-1:0];
            rd_ptr     <= rd_ptr + PTR_W'(pop);
            count      <= count + npush[PTR_W:0] - (PTR_W+1)'(pop);
            if (ndrop != '0) overflow <= 1'b1;
            drop_cnt   <= sat_add16(drop_cnt, ndrop);
        end
    end

    // Event storage: payload only, qualified by count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset && wr_en[i]) begin
                fifo_code[wr_idx[i]]   <= ev_code[i];
                fifo_slot[wr_idx[i]]   <= SLOT_W'(i);
                fifo_time[wr_idx[i]]   <= now;
                fifo_cycles[wr_idx[i]] <= ev_cycles[i];
                fifo_unm[wr_idx[i]]    <= ev_unm[i];
`ifdef PHASE_TAINT_PEAK_EN
                fifo_peak[wr_idx[i]]   <= ev_peak[i];
`endif
            end
        end
    end

    assign evt_code       = evt_valid ? fifo_code[rd_ptr]   : '0;
    assign evt_slot       = evt_valid ? fifo_slot[rd_ptr]   : '0;
    assign evt_time       = evt_valid ? fifo_time[rd_ptr]   : '0;
    assign evt_cycles     = evt_valid ? fifo_cycles[rd_ptr] : '0;
    assign evt_unmatched  = evt_valid ? fifo_unm[rd_ptr]    : 1'b0;
`ifdef PHASE_TAINT_PEAK_EN
    assign evt_taint_peak = evt_valid ? fifo_peak[rd_ptr]   : '0;
`else
    assign evt_taint_peak = '0;
`endif
    assign active_phases  = active;
endmodule

// File: tb/tb_rob_phase_tracker.sv
// Scoreboard bench for rob_phase_tracker (NCH=2, FIFO_DEPTH=8, CNT_W=8, TAINT_W=16).
module tb_rob_phase_tracker;
    localparam int NCH = 2, DEPTH = 8, CNT_W = 8, TW = 16;
`ifdef PHASE_TAINT_PEAK_EN
    localparam logic [15:0] TEXE_PEAK = 16'd9;
`else
    localparam logic [15:0] TEXE_PEAK = 16'd0;
`endif

    typedef struct packed {
        logic [3:0]  code;
        logic [0:0]  slot;
        logic [7:0]  tim;
        logic [7:0]  cyc;
        logic        unm;
        logic [15:0] peak;
    } evt_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    commit_valid;
    logic [NCH*32-1:0] commit_inst;
    logic [TW-1:0]     taint_sum;
    logic              evt_valid, evt_ready, evt_unmatched, overflow;
    logic [3:0]        evt_code;
    logic [0:0]        evt_slot;
    logic [CNT_W-1:0]  evt_time, evt_cycles;
    logic [TW-1:0]     evt_taint_peak;
    logic [6:0]        active_phases;
    logic [15:0]       drop_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tb_cyc   = 0;
    evt_t exp_q[$];

    rob_phase_tracker #(.NCH(NCH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W), .TAINT_W(TW)) dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .taint_sum(taint_sum), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_slot(evt_slot), .evt_time(evt_time), .evt_cycles(evt_cycles),
        .evt_unmatched(evt_unmatched), .evt_taint_peak(evt_taint_peak),
        .active_phases(active_phases), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    // Reference cycle counter: equals the DUT timestamp of the next sampled edge.
    always @(posedge clock) begin
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_until(input int n);
        commit_valid = '0;
        if (tb_cyc > n) check("schedule", 64'(tb_cyc), 64'(n));
        while (tb_cyc < n) step();
    endtask

    task automatic drive(input logic v0, input logic [31:0] i0, input logic v1, input logic [31:0] i1);
        commit_valid = {v1, v0};
        commit_inst  = {i1, i0};
        step();
        commit_valid = '0;
    endtask

    task automatic expect_evt(input logic [3:0] c, input logic s, input int t, input int cy,
                              input logic u, input logic [15:0] p);
        evt_t e;
        e.code = c; e.slot = s; e.tim = t[7:0]; e.cyc = cy[7:0]; e.unm = u; e.peak = p;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge clock) begin
        evt_t got, e;
        if (reset && evt_valid && evt_ready) begin
            got = '{code: evt_code, slot: evt_slot, tim: evt_time, cyc: evt_cycles,
                    unm: evt_unmatched, peak: evt_taint_peak};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_evt: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                check("evt", 64'(got), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; commit_valid = '0; commit_inst = '0; taint_sum = '0; evt_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_fields", {evt_code, evt_slot, evt_time, evt_cycles, evt_unmatched, evt_taint_peak}, 64'd0);
        check("rst_active", 64'(active_phases), 64'd0);
        check("rst_ovf_drop", {overflow, drop_cnt}, 64'd0);
        reset = 1'b1;

        // Basic start/end of VCTM
        idle_until(10);
        expect_evt(4'd0, 1'b0, 10, 0, 1'b0, 16'd0);
        drive(1'b1, 32'h00002013, 1'b0, 32'h0);
        check("vctm_active", 64'(active_phases[0]), 64'd1);
        idle_until(25);
        expect_evt(4'd1, 1'b0, 25, 15, 1'b0, 16'd0);
        drive(1'b1, 32'h00102013, 1'b0, 32'h0);
        check("vctm_cleared", 64'(active_phases[0]), 64'd0);

        // Same-cycle start+end across slots
        idle_until(30);
        expect_evt(4'd4, 1'b0, 30, 0, 1'b0, 16'd0);
        expect_evt(4'd5, 1'b1, 30, 0, 1'b0, 16'd0);
        drive(1'b1, 32'h00402013, 1'b1, 32'h00502013);
        check("texe_same_cycle", 64'(active_phases[2]), 64'd0);

        // Unmatched end and ignored encodings
        idle_until(35);
        expect_evt(4'd7, 1'b0, 35, 0, 1'b1, 16'd0);
        drive(1'b1, 32'h00702013, 1'b0, 32'h0);
        drive(1'b1, 32'h00e02013, 1'b0, 32'h0);
        drive(1'b0, 32'h00002013, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h01002013);
        idle_until(42);
        check("empty_valid", 64'(evt_valid), 64'd0);
        check("empty_fields", {evt_code, evt_slot, evt_time, evt_cycles, evt_unmatched}, 64'd0);
        check("idle_active", 64'(active_phases), 64'd0);

        // Taint peak over TEXE
        idle_until(45);
        taint_sum = 16'd3;
        expect_evt(4'd4, 1'b0, 45, 0, 1'b0, 16'd0);
        drive(1'b1, 32'h00402013, 1'b0, 32'h0);
        taint_sum = 16'd9;
        step();
        taint_sum = 16'd4;
        expect_evt(4'd5, 1'b0, 47, 2, 1'b0, TEXE_PEAK);
        drive(1'b1, 32'h00502013, 1'b0, 32'h0);
        taint_sum = 16'd0;

        // Overflow with stalled consumer
        idle_until(55);
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                expect_evt(4'd8, 1'b0, 55 + k, 0, 1'b0, 16'd0);
                expect_evt(4'd10, 1'b1, 55 + k, 0, 1'b0, 16'd0);
            end
            drive(1'b1, 32'h00802013, 1'b1, 32'h00a02013);
        end
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
        check("ovf_active", 64'(active_phases), 64'h30);
        idle_until(62);
        check("stall_head", {evt_valid, evt_code, evt_time}, {1'b1, 4'd8, 8'd55});
        evt_ready = 1'b1;
        expect_evt(4'd9, 1'b0, 62, 3, 1'b0, 16'd0);
        drive(1'b1, 32'h00902013, 1'b0, 32'h0);
        check("pop_push_no_drop", {overflow, drop_cnt}, {1'b1, 16'd2});
        idle_until(75);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(evt_valid), 64'd0);

        // Timestamp wrap
        idle_until(253);
        expect_evt(4'd12, 1'b0, 253, 0, 1'b0, 16'd0);
        drive(1'b1, 32'h00c02013, 1'b0, 32'h0);
        idle_until(258);
        expect_evt(4'd13, 1'b0, 2, 5, 1'b0, 16'd0);
        drive(1'b1, 32'h00d02013, 1'b0, 32'h0);
        idle_until(265);
        check("wrap_queue", 64'(exp_q.size()), 64'd0);

        // Reset with phase active and FIFO occupied
        evt_ready = 1'b0;
        drive(1'b1, 32'h00202013, 1'b0, 32'h0);
        check("pre_rst_state", {evt_valid, active_phases[1]}, 64'd3);
        reset = 1'b0;
        drive(1'b1, 32'h00402013, 1'b0, 32'h0);
        check("mid_rst_valid", 64'(evt_valid), 64'd0);
        check("mid_rst_fields", {evt_code, evt_time, evt_cycles, evt_unmatched}, 64'd0);
        check("mid_rst_state", {active_phases, overflow, drop_cnt}, 64'd0);
        reset = 1'b1;
        evt_ready = 1'b1;
        expect_evt(4'd6, 1'b1, 0, 0, 1'b0, 16'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h00602013);
        repeat (10) step();
        check("final_queue", 64'(exp_q.size()), 64'd0);
        check("final_active", 64'(active_phases), 64'h08);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
